apb_bridge: RTL and testbench

Converts the single-cycle slave-2 port of the system bus into APB3 SETUP/ACCESS transfers for the peripheral region starting at 0x4000D000 (UART and later peripherals).
- Captures one bus request, decodes it to one of NUM_SLAVES 4 KB peripheral slots, and runs the APB handshake.
- Raises hold_o to stall the pipeline until the transfer completes; the top level ORs hold_o into the pipeline hold.
- Sits directly downstream of the bus slave-2 outputs.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_bridge_if.sv | 32 +++
 rtl/apb_addr_decode.sv | 21 ++
 rtl/apb_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_bridge.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB bridge and its address decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  localparam logic [31:0] APB_BASE_ADDR  = 32'h4000D000;
  localparam int          APB_SLOT_SHIFT = 12;
  localparam int          APB_NUM_SLAVES = 4;

  // Slot index width; never zero so a single-slave build still has a port.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_bridge_if.sv
// Bus-side request/response and APB-side signals of the bridge.
// Handshake: a request is presented by holding hsel_i high with addr_i/hwdata_i/we_i stable while hold_o is high;
// the response (hrdata_o, err_o) is valid only in the single cycle after hold_o falls.
interface apb_bridge_if #(
  parameter int NUM_SLAVES = apb_pkg::APB_NUM_SLAVES
);
  logic                    hsel_i;
  logic [31:0]             addr_i;
  logic [31:0]             hwdata_i;
  logic                    we_i;
  logic [31:0]             hrdata_o;
  logic                    hold_o;
  logic                    err_o;
  logic [31:0]             paddr_o;
  logic [NUM_SLAVES-1:0]   psel_o;
  logic                    penable_o;
  logic                    pwrite_o;
  logic [31:0]             pwdata_o;
  logic [32*NUM_SLAVES-1:0] prdata_i;
  logic [NUM_SLAVES-1:0]   pready_i;
  logic [NUM_SLAVES-1:0]   pslverr_i;

  modport master (
    output hsel_i, addr_i, hwdata_i, we_i, prdata_i, pready_i, pslverr_i,
    input  hrdata_o, hold_o, err_o, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
  );

  modport slave (
    input  hsel_i, addr_i, hwdata_i, we_i, prdata_i, pready_i, pslverr_i,
    output hrdata_o, hold_o, err_o, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Maps a bus address onto a 4 KB peripheral slot index plus a mapped flag.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = APB_BASE_ADDR,
  parameter int          NUM_SLAVES = APB_NUM_SLAVES,
  parameter int          SLOT_W     = slot_w(NUM_SLAVES)
) (
  input  logic [31:0]       addr_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              mapped_o
);

  logic [31:0] slot_full;

  // Below-base addresses wrap to a huge slot; the base compare rejects them explicitly.
  assign slot_full = (addr_i - BASE_ADDR) >> APB_SLOT_SHIFT;
  assign mapped_o  = (addr_i >= BASE_ADDR) && (slot_full < 32'(NUM_SLAVES));
  assign slot_o    = slot_full[SLOT_W-1:0];

endmodule

// File: rtl/apb_bridge.sv
// Single-request bus to APB3 bridge: decode, SETUP/ACCESS handshake, timeout abort, pipeline hold.
module apb_bridge
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = APB_BASE_ADDR,
  parameter int          NUM_SLAVES     = APB_NUM_SLAVES,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  apb_bridge_if.slave bus,
  output apb_state_e  state_o
);

  localparam int SW = slot_w(NUM_SLAVES);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  apb_state_e            state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [31:0]           hrdata_q, hrdata_d;
  logic                  err_q, err_d;

  logic [SW-1:0] dec_slot;
  logic          dec_mapped;
  logic          sel_ready, sel_err;
  logic [31:0]   sel_rdata;

  apb_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .NUM_SLAVES (NUM_SLAVES),
    .SLOT_W     (SW)
  ) u_decode (
    .addr_i   (bus.addr_i),
    .slot_o   (dec_slot),
    .mapped_o (dec_mapped)
  );

  // Only the captured slot's ready/error/data are visible to the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (slot_q == SW'(k)) begin
        sel_ready = bus.pready_i[k];
        sel_err   = bus.pslverr_i[k];
        sel_rdata = bus.prdata_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    hrdata_d  = hrdata_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.hsel_i) begin
          if (dec_mapped) begin
            paddr_d  = bus.addr_i;
            pwdata_d = bus.hwdata_i;
            pwrite_d = bus.we_i;
            slot_d   = dec_slot;
            psel_d   = '0;
            psel_d[dec_slot] = 1'b1;
            state_d  = ST_SETUP;
          end else begin
            err_d    = 1'b1;
            hrdata_d = '0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (sel_ready) begin
          hrdata_d  = pwrite_q ? 32'h0 : sel_rdata;
          err_d     = sel_err;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          hrdata_d  = '0;
          err_d     = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      hrdata_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      hrdata_q  <= hrdata_d;
      err_q     <= err_d;
    end
  end

  // The stall must appear in the request cycle itself, so IDLE passes hsel_i straight through.
  assign bus.hold_o    = (state_q == ST_IDLE) ? bus.hsel_i : (state_q != ST_DONE);
  assign bus.hrdata_o  = hrdata_q;
  assign bus.err_o     = err_q;
  assign bus.paddr_o   = paddr_q;
  assign bus.psel_o    = psel_q;
  assign bus.penable_o = penable_q;
  assign bus.pwrite_o  = pwrite_q;
  assign bus.pwdata_o  = pwdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_apb_bridge.sv
// Directed bench for apb_bridge: per-cycle handshake checks plus a response scoreboard.
module tb_apb_bridge;
  import apb_pkg::*;

  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  apb_bridge_if #(.NUM_SLAVES(NS)) bus ();
  apb_state_e state;

  apb_bridge #(
    .BASE_ADDR      (32'h4000D000),
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request cycle T: drive, check the same-cycle hold, advance to T+1 and release hsel.
  task automatic start_req(input logic [31:0] addr, input logic [31:0] data, input logic we,
                           input bit push, input logic exp_err, input logic [31:0] exp_data);
    bus.hsel_i   = 1'b1;
    bus.addr_i   = addr;
    bus.hwdata_i = data;
    bus.we_i     = we;
    if (push) exp_q.push_back({exp_err, exp_data});
    #1;
    check("req_hold", {63'd0, bus.hold_o}, 64'd1);
    check("req_state", {62'd0, state}, {62'd0, ST_IDLE});
    step();
    bus.hsel_i = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_sb: observed response, expected none queued", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_err"}, {63'd0, bus.err_o}, {63'd0, e[32]});
      check({tag, "_rdata"}, {32'd0, bus.hrdata_o}, {32'd0, e[31:0]});
    end
  endtask

  // Entered at T+1. Plays the selected slave (ready after 'waits' ACCESS cycles), then checks DONE.
  task automatic wait_done(input int slot, input int waits, input int exp_lat, input string tag);
    int lat = 1;
    int acc = 0;
    while (state != ST_DONE && lat < 40) begin
      check({tag, "_hold_busy"}, {63'd0, bus.hold_o}, 64'd1);
      if (state == ST_ACCESS) begin
        bus.pready_i[slot] = (acc == waits);
        acc++;
      end
      step();
      lat++;
    end
    bus.pready_i[slot] = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hold_done"}, {63'd0, bus.hold_o}, 64'd0);
    check({tag, "_psel_done"}, {60'd0, bus.psel_o}, 64'd0);
    check({tag, "_penable_done"}, {63'd0, bus.penable_o}, 64'd0);
    sb_check(tag);
    step();
    check({tag, "_err_pulse"}, {63'd0, bus.err_o}, 64'd0);
    check({tag, "_back_idle"}, {62'd0, state}, {62'd0, ST_IDLE});
  endtask

  initial begin
    bus.hsel_i    = 1'b0;
    bus.addr_i    = '0;
    bus.hwdata_i  = '0;
    bus.we_i      = 1'b0;
    bus.prdata_i  = '0;
    bus.pready_i  = '0;
    bus.pslverr_i = '0;

    // Reset values
    repeat (3) step();
    check("rst_state", {62'd0, state}, {62'd0, ST_IDLE});
    check("rst_psel", {60'd0, bus.psel_o}, 64'd0);
    check("rst_penable", {63'd0, bus.penable_o}, 64'd0);
    check("rst_pwrite", {63'd0, bus.pwrite_o}, 64'd0);
    check("rst_paddr", {32'd0, bus.paddr_o}, 64'd0);
    check("rst_pwdata", {32'd0, bus.pwdata_o}, 64'd0);
    check("rst_hrdata", {32'd0, bus.hrdata_o}, 64'd0);
    check("rst_err", {63'd0, bus.err_o}, 64'd0);
    check("rst_hold", {63'd0, bus.hold_o}, 64'd0);
    rst = 1'b1;
    step();

    // 1: zero-wait write to slot 0, cycle by cycle
    bus.pready_i[0] = 1'b1;
    start_req(32'h4000D004, 32'hA5A50001, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_setup_state", {62'd0, state}, {62'd0, ST_SETUP});
    check("t1_setup_psel", {60'd0, bus.psel_o}, 64'h1);
    check("t1_setup_penable", {63'd0, bus.penable_o}, 64'd0);
    check("t1_paddr", {32'd0, bus.paddr_o}, 64'h4000D004);
    check("t1_pwdata", {32'd0, bus.pwdata_o}, 64'hA5A50001);
    check("t1_pwrite", {63'd0, bus.pwrite_o}, 64'd1);
    check("t1_setup_hold", {63'd0, bus.hold_o}, 64'd1);
    step();
    check("t1_access_state", {62'd0, state}, {62'd0, ST_ACCESS});
    check("t1_access_psel", {60'd0, bus.psel_o}, 64'h1);
    check("t1_access_penable", {63'd0, bus.penable_o}, 64'd1);
    check("t1_access_hold", {63'd0, bus.hold_o}, 64'd1);
    check("t1_access_pwdata", {32'd0, bus.pwdata_o}, 64'hA5A50001);
    step();
    check("t1_done_state", {62'd0, state}, {62'd0, ST_DONE});
    check("t1_done_hold", {63'd0, bus.hold_o}, 64'd0);
    sb_check("t1");
    bus.pready_i[0] = 1'b0;
    step();
    check("t1_back_idle", {62'd0, state}, {62'd0, ST_IDLE});
    check("t1_paddr_held", {32'd0, bus.paddr_o}, 64'h4000D004);

    // 2: slot 1 read with 3 wait states
    bus.prdata_i[32*1 +: 32] = 32'h12345678;
    start_req(32'h4000E010, 32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678);
    check("t2_psel", {60'd0, bus.psel_o}, 64'h2);
    wait_done(1, 3, 6, "t2");

    // 3: slot 4 is past the last peripheral
    start_req(32'h40011000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    wait_done(0, 0, 1, "t3");

    // 3b: just below the region base
    start_req(32'h4000CFFC, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    wait_done(0, 0, 1, "t3b");

    // 4: slot 2 never ready, timeout abort
    bus.prdata_i[32*2 +: 32] = 32'hFFFF0000;
    start_req(32'h4000F000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    check("t4_psel", {60'd0, bus.psel_o}, 64'h4);
    wait_done(2, 1000, 18, "t4");

    // 5: slot 3 slave error, slot 0 ready held high throughout
    bus.pready_i[0]          = 1'b1;
    bus.pslverr_i[3]         = 1'b1;
    bus.prdata_i[32*3 +: 32] = 32'hDEADBEEF;
    start_req(32'h40010020, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    check("t5_psel", {60'd0, bus.psel_o}, 64'h8);
    wait_done(3, 1, 4, "t5");
    bus.pready_i[0]  = 1'b0;
    bus.pslverr_i[3] = 1'b0;

    // 6: reset during ACCESS, then a clean transfer
    start_req(32'h4000E000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("t6_in_access", {62'd0, state}, {62'd0, ST_ACCESS});
    rst = 1'b0;
    step();
    check("t6_rst_state", {62'd0, state}, {62'd0, ST_IDLE});
    check("t6_rst_psel", {60'd0, bus.psel_o}, 64'd0);
    check("t6_rst_penable", {63'd0, bus.penable_o}, 64'd0);
    check("t6_rst_hold", {63'd0, bus.hold_o}, 64'd0);
    check("t6_rst_hrdata", {32'd0, bus.hrdata_o}, 64'd0);
    rst = 1'b1;
    step();
    bus.prdata_i[32*0 +: 32] = 32'hCAFEF00D;
    start_req(32'h4000D100, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D);
    wait_done(0, 0, 3, "t6b");

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
